// File: rtl/ireg_pkg.sv
// Shared types and helpers for the per-channel skew/delay pipeline.
package ireg_pkg;

  // Widest per-channel payload a stage record can carry.
  localparam int unsigned MaxWidth = 32;

  // One pipeline stage: token valid, sign bit and magnitude/temporal payload.
  typedef struct packed {
    logic                valid;
    logic                sign;
    logic [MaxWidth-1:0] dff;
  } stage_t;

  // Width of a delay register able to hold the values 0..depth.
  function automatic int unsigned calc_dw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Clamp a requested delay into the usable range 1..depth.
  function automatic int unsigned sat_delay(input int unsigned raw, input int unsigned depth);
    if (raw == 0) begin
      return 1;
    end else if (raw > depth) begin
      return depth;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/ireg_chan_delay.sv
// Single-channel programmable delay line: stage array, delay register,
// output tap mux and a local "any token in the active window" flag.
module ireg_chan_delay
  import ireg_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 8,
  parameter int unsigned Dw    = calc_dw(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             cfg_load_i,
  input  logic [Dw-1:0]    cfg_delay_i,
  input  logic             valid_i,
  input  logic             sign_i,
  input  logic [Width-1:0] dff_i,
  output logic             valid_o,
  output logic             sign_o,
  output logic [Width-1:0] dff_o,
  output logic             any_valid_o
);

  stage_t        stage_q [Depth];
  stage_t        stage_d [Depth];
  logic [Dw-1:0] dly_q, dly_d;
  logic [Dw-1:0] eff_d;
  logic [Dw-1:0] sel_idx;
  stage_t        sel;
  logic          unused_sel;

  // Next-state for the stage array: flush on clear/load, else shift when enabled.
  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (clr_i || cfg_load_i) begin
      // Input presented alongside a flush is dropped as well.
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_d[i] = '0;
      end
    end else if (en_i) begin
      stage_d[0]                = '0;
      stage_d[0].valid          = valid_i;
      stage_d[0].sign           = valid_i & sign_i;
      stage_d[0].dff[Width-1:0] = valid_i ? dff_i : '0;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Next-state for the delay register; only cfg_load changes it.
  always_comb begin
    dly_d = dly_q;
    if (cfg_load_i) begin
      dly_d = cfg_delay_i;
    end
  end

  // State registers with synchronous reset; delay comes out of reset as 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
      dly_q <= Dw'(1);
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
      dly_q <= dly_d;
    end
  end

  // Effective delay, output tap selection and active-window occupancy.
  always_comb begin
    eff_d       = Dw'(sat_delay(int'(dly_q), Depth));
    sel_idx     = eff_d - Dw'(1);
    sel         = '0;
    any_valid_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (Dw'(i) == sel_idx) begin
        sel = stage_q[i];
      end
      // Stages past the tap may hold stale tokens; they must not count.
      if (Dw'(i) < eff_d) begin
        any_valid_o = any_valid_o | stage_q[i].valid;
      end
    end
  end

  assign valid_o    = sel.valid;
  assign sign_o     = sel.sign;
  assign dff_o      = sel.dff[Width-1:0];
  assign unused_sel = ^sel;

endmodule

// File: rtl/ireg_skew_pipe.sv
// Multi-channel skew pipeline: CH independent programmable delay lines
// plus a global "nothing in flight" indicator.
module ireg_skew_pipe
  import ireg_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned DW   = calc_dw(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                cfg_load,
  input  logic [CH*DW-1:0]    cfg_delay,
  input  logic [CH-1:0]       i_valid,
  input  logic [CH-1:0]       i_data_sign,
  input  logic [CH*WIDTH-1:0] i_data_dff,
  output logic [CH-1:0]       o_valid,
  output logic [CH-1:0]       o_data_sign,
  output logic [CH*WIDTH-1:0] o_data_dff,
  output logic                o_empty
);

  logic [CH-1:0] any_valid;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    ireg_chan_delay #(
      .Width (WIDTH),
      .Depth (DEPTH),
      .Dw    (DW)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .clr_i       (clr),
      .cfg_load_i  (cfg_load),
      .cfg_delay_i (cfg_delay[c*DW +: DW]),
      .valid_i     (i_valid[c]),
      .sign_i      (i_data_sign[c]),
      .dff_i       (i_data_dff[c*WIDTH +: WIDTH]),
      .valid_o     (o_valid[c]),
      .sign_o      (o_data_sign[c]),
      .dff_o       (o_data_dff[c*WIDTH +: WIDTH]),
      .any_valid_o (any_valid[c])
    );
  end

  assign o_empty = ~|any_valid;

endmodule
